dccm_ctrl: RTL
==============

Name: dccm_ctrl

Overview:
- Data closely-coupled memory (DCCM): the responder end of the load/store unit's DCCM port.
- Accepts word addresses, store type/offset and raw (unshifted) store data from the LSU.
- Performs byte-lane write merging into a word-organised array.
- Returns the full aligned word for loads one cycle later; the LSU does lane extraction and sign extension.
- Sits beside the MEM stage; the array is private to this block.

Parameters:
- DEPTH_WORDS, 4096, number of 32-bit words in the array (16 KiB); power of two.
- BASE_ADDR, 32'h0001_0000, byte address of word 0; aligned to DEPTH_WORDS*4.
- AW, $clog2(DEPTH_WORDS), word-index width (derived, not overridden).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- dccm_wr_en_i  in  1  store request this cycle
- dccm_rd_en_i  in  1  load request this cycle
- dccm_wr_addr_i  in  32  store byte address
- dccm_rd_addr_i  in  32  load byte address
- store_type_i  in  2  00 none, 01 byte, 10 half, 11 word
- store_offset_i  in  2  byte offset of the store (wr_addr[1:0])
- dccm_wr_data_i  in  32  raw store data, value in low bits
- dccm_rd_data_o  out  32  aligned word read, valid the cycle after dccm_rd_en_i
- dccm_err_o  out  1  sticky error flag (out-of-range or misaligned access)
- dccm_err_addr_o  out  32  byte address of the first erroring access

Behaviour:
- Reset: dccm_rd_data_o=0, dccm_err_o=0, dccm_err_addr_o=0, pending-read state cleared.
- Array contents are not reset.
- Asynchronous assert; synchronous deassert is the top level's job.
- Hit: addr[31:AW+2] == BASE_ADDR[31:AW+2]. Word index = addr[AW+1:2].
- Store, executed at the clk edge when dccm_wr_en_i=1, hit, and aligned:
  - byte: lane = offset; data byte wr_data[7:0] goes to that lane; mask 1<<offset.
  - half: offset must be 0 or 2; wr_data[15:0] goes to lanes offset..offset+1; mask 0011 or 1100.
  - word: offset must be 0; all lanes written.
  - Unmasked lanes keep their previous contents.
- store_type 00 with dccm_wr_en_i=1: no write, no error.
- Misaligned store (half at offset 1/3, word at offset≠0): write dropped, error raised.
- Miss on store: write dropped, error raised.
- Load: when dccm_rd_en_i=1 and hit, the word at the index is registered to dccm_rd_data_o at the next edge (latency 1). dccm_rd_addr_i[1:0] is ignored.
- Miss on load: dccm_rd_data_o <= 0, error raised.
- No load: dccm_rd_data_o holds its last value.
- Simultaneous rd/wr to the same word in one cycle: read returns the pre-write contents (read-before-write).
- Load in the cycle after a store to the same word sees the new data (no bypass needed).
- Error capture: on the first error while dccm_err_o=0, set dccm_err_o=1 and capture the offending byte address. Store error has priority over load error in the same cycle. Later errors do not overwrite. Cleared only by reset.
- Reset mid-read: pending data discarded; output is 0 after reset.
- No back-pressure: a request is accepted every cycle.

Decomposition:
- Shared package dccm_pkg:
  - store-type constants ST_NONE/ST_B/ST_H/ST_W;
  - default BASE_ADDR and DEPTH_WORDS;
  - byte-mask/lane-shift function.
- One natural sub-module: dccm_ram_1r1w, a plain DEPTH_WORDS x 32 array with 4-bit byte-write mask and registered read port (read-before-write). It is swappable for an SRAM macro later.
- dccm_ctrl contains address decode, mask/shift generation, the output data register and the error register.

Test Plan:
- Reset then SW 0xDEADBEEF @0x0001_0010, next cycle LW @0x0001_0010 -> dccm_rd_data_o=0xDEADBEEF one cycle after the load; err_o=0.
- Over that word: SB 0x000000AA offset 1, SH 0x00001234 offset 2, then load -> 0x1234AAEF.
- Same-cycle SW 0x11111111 and LW to word 0x0001_0020 (old 0x22222222) -> read returns 0x22222222; next load returns 0x11111111.
- SH @0x0001_0013 (offset 3) -> word unchanged; err_o=1, err_addr_o=0x0001_0013. Then LW @0x0000_0000 -> rd_data=0, err_addr_o stays 0x0001_0013.
- Load with no further rd_en for 5 cycles -> rd_data_o holds the value. Assert rst_n low mid-stream -> rd_data_o=0 and err_o=0 immediately (asynchronously).
- Write-then-read the first and last words (0x0001_0000, 0x0001_3FFC) -> data correct, no aliasing. LW @0x0001_4000 -> miss, rd_data=0, err_o=1.

Source files
------------

// File: rtl/dccm_pkg.sv
// dccm_pkg: shared constants and helpers for the DCCM responder.
//   - Store-type encodings (ST_NONE/ST_B/ST_H/ST_W) as driven by the LSU.
//   - Default array geometry (DCCM_DEPTH_WORDS) and base byte address (DCCM_BASE_ADDR).
//   - store_aligned: whether a store type/offset pair is naturally aligned.
//   - store_mask:    byte-lane write mask for a store.
//   - store_lanes:   raw low-justified store data shifted onto its byte lanes.
package dccm_pkg;

    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_B    = 2'b01;
    localparam logic [1:0] ST_H    = 2'b10;
    localparam logic [1:0] ST_W    = 2'b11;

    localparam int unsigned DCCM_DEPTH_WORDS = 4096;
    localparam logic [31:0] DCCM_BASE_ADDR   = 32'h0001_0000;

    function automatic logic store_aligned(input logic [1:0] st, input logic [1:0] off);
        logic ok;
        ok = 1'b1;
        case (st)
            ST_H:    ok = (off[0] == 1'b0);
            ST_W:    ok = (off == 2'b00);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] store_mask(input logic [1:0] st, input logic [1:0] off);
        logic [3:0] m;
        m = 4'b0000;
        case (st)
            ST_B:    m = 4'b0001 << off;
            ST_H:    m = 4'b0011 << off;
            ST_W:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Bytes that land on unmasked lanes are don't-care; the mask discards them.
    function automatic logic [31:0] store_lanes(input logic [31:0] d, input logic [1:0] off);
        return d << {off, 3'b000};
    endfunction

endpackage

// File: rtl/dccm_ram_1r1w.sv
// dccm_ram_1r1w: DEPTH x 32-bit array, one write port with 4-bit byte mask and
// one registered read port. A read and write to the same word in one cycle
// returns the pre-write contents. Contents are not reset; drop-in slot for an
// SRAM macro.
//   clk    in  clock
//   we     in  write enable
//   wmask  in  byte-lane write mask
//   waddr  in  write word index
//   wdata  in  lane-aligned write data
//   re     in  read enable (rdata holds when low)
//   raddr  in  read word index
//   rdata  out registered read data
module dccm_ram_1r1w #(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    wmask,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dccm_ctrl.sv
// dccm_ctrl: DCCM responder for the LSU. Decodes store/load byte addresses
// against the DCCM window, builds byte masks, writes the array and returns the
// full aligned word one cycle after a load. A sticky error register captures
// the first out-of-range or misaligned access.
// Request semantics: a request is taken on every clk edge where its enable is
// high; there is no ready/back-pressure, so the LSU never stalls on this port.
//   clk, rst_n        clock, asynchronous active-low reset
//   dccm_wr_en_i      store request
//   dccm_rd_en_i      load request
//   dccm_wr_addr_i    store byte address
//   dccm_rd_addr_i    load byte address (bits [1:0] ignored)
//   store_type_i      ST_NONE/ST_B/ST_H/ST_W
//   store_offset_i    store byte offset
//   dccm_wr_data_i    raw store data, low-justified
//   dccm_rd_data_o    aligned load word, valid the cycle after dccm_rd_en_i
//   dccm_err_o        sticky error flag
//   dccm_err_addr_o   byte address of the first erroring access
module dccm_ctrl
    import dccm_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DCCM_DEPTH_WORDS,
    parameter logic [31:0] BASE_ADDR   = DCCM_BASE_ADDR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dccm_wr_en_i,
    input  logic        dccm_rd_en_i,
    input  logic [31:0] dccm_wr_addr_i,
    input  logic [31:0] dccm_rd_addr_i,
    input  logic [1:0]  store_type_i,
    input  logic [1:0]  store_offset_i,
    input  logic [31:0] dccm_wr_data_i,
    output logic [31:0] dccm_rd_data_o,
    output logic        dccm_err_o,
    output logic [31:0] dccm_err_addr_o
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic        wr_hit, rd_hit, st_ok;
    logic        wr_req, wr_do, wr_err, rd_do, rd_err;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] ram_rdata;
    logic        rd_sel_q;
    logic        err_q;
    logic [31:0] err_addr_q;
    logic        unused_addr_bits;

    assign wr_hit = (dccm_wr_addr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign rd_hit = (dccm_rd_addr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign st_ok  = store_aligned(store_type_i, store_offset_i);

    // ST_NONE with the enable high is a no-op, not an error.
    assign wr_req = dccm_wr_en_i && (store_type_i != ST_NONE);
    assign wr_do  = wr_req && wr_hit && st_ok;
    assign wr_err = wr_req && !(wr_hit && st_ok);
    assign rd_do  = dccm_rd_en_i && rd_hit;
    assign rd_err = dccm_rd_en_i && !rd_hit;

    assign wmask = store_mask(store_type_i, store_offset_i);
    assign wdata = store_lanes(dccm_wr_data_i, store_offset_i);

    // Byte offsets come from store_offset_i; loads return whole words.
    assign unused_addr_bits = ^{dccm_wr_addr_i[1:0], dccm_rd_addr_i[1:0]};

    dccm_ram_1r1w #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_do),
        .wmask (wmask),
        .waddr (dccm_wr_addr_i[AW+1:2]),
        .wdata (wdata),
        .re    (rd_do),
        .raddr (dccm_rd_addr_i[AW+1:2]),
        .rdata (ram_rdata)
    );

    // The array read register is not reset and only updates on hits, so the
    // output is gated by a reset flop: 0 after reset or a load miss, otherwise
    // the last word read (which the array register holds between loads).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sel_q   <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            if (dccm_rd_en_i) begin
                rd_sel_q <= rd_hit;
            end
            // First error wins; a store error outranks a load error in the same cycle.
            if (!err_q) begin
                if (wr_err) begin
                    err_q      <= 1'b1;
                    err_addr_q <= dccm_wr_addr_i;
                end else if (rd_err) begin
                    err_q      <= 1'b1;
                    err_addr_q <= dccm_rd_addr_i;
                end
            end
        end
    end

    assign dccm_rd_data_o  = rd_sel_q ? ram_rdata : 32'h0;
    assign dccm_err_o      = err_q;
    assign dccm_err_addr_o = err_addr_q;

endmodule
